// File: rtl/proc_mc.sv
// Multi-cycle RV32I(+MUL) core: one instruction at a time over a single req/ack memory port,
// with MMIO stores driving an integer/float console and a sticky halt.
module proc_mc #(
  parameter logic [31:0] RESET_PC  = 32'd0,
  parameter int unsigned NUM_REGS  = 32,
  parameter bit          ENABLE_M  = 1'b1,
  parameter logic [31:0] OUT_ADDR  = 32'd1000,
  parameter logic [31:0] HALT_ADDR = 32'd1004,
  parameter logic [31:0] OUTF_ADDR = 32'd1008
) (
  input  logic        clk_i,
  input  logic        rst_i,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wr_data_o,
  output logic        mem_wr_req_o,
  output logic        mem_rd_req_o,
  input  logic [31:0] mem_rd_data_i,
  input  logic        mem_ack_i,
  input  logic        mem_busy_i,
  output logic [31:0] out_o,
  output logic        outen_o,
  output logic        outflen_o,
  output logic        halt_o,
  output logic [31:0] pc_o,
  output logic [2:0]  state_o,
  output logic [31:0] x1_o
);
  localparam int unsigned RegAw = $clog2(NUM_REGS);

  typedef enum logic [2:0] {
    StFetch  = 3'd0,
    StIwait  = 3'd1,
    StExec   = 3'd2,
    StDwait  = 3'd3,
    StHalted = 3'd4
  } state_e;

  localparam logic [6:0] OpLoad   = 7'h03;
  localparam logic [6:0] OpImm    = 7'h13;
  localparam logic [6:0] OpAuipc  = 7'h17;
  localparam logic [6:0] OpStore  = 7'h23;
  localparam logic [6:0] OpReg    = 7'h33;
  localparam logic [6:0] OpLui    = 7'h37;
  localparam logic [6:0] OpBranch = 7'h63;
  localparam logic [6:0] OpJalr   = 7'h67;
  localparam logic [6:0] OpJal    = 7'h6f;

  state_e      state_q;
  logic [31:0] pc_q, ir_q, mem_addr_q, mem_wr_data_q, out_q;
  logic        mem_rd_req_q, mem_wr_req_q, outen_q, outflen_q, halt_q, issued_q;
  logic [31:0] regs_q [NUM_REGS];

  logic [6:0]  opcode, funct7;
  logic [2:0]  funct3;
  logic [4:0]  rd, rs1, rs2;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic [31:0] rs1_val, rs2_val, op_b, mul_res, alu_res, wb_data, ea, pc_plus4, next_pc;
  logic [4:0]  shamt;
  logic        br_taken, illegal, use_rd, use_rs1, use_rs2;

  function automatic logic reg_ok(input logic [4:0] idx);
    return {27'd0, idx} < NUM_REGS;
  endfunction

  assign opcode = ir_q[6:0];
  assign rd     = ir_q[11:7];
  assign funct3 = ir_q[14:12];
  assign rs1    = ir_q[19:15];
  assign rs2    = ir_q[24:20];
  assign funct7 = ir_q[31:25];
  assign imm_i  = {{20{ir_q[31]}}, ir_q[31:20]};
  assign imm_s  = {{20{ir_q[31]}}, ir_q[31:25], ir_q[11:7]};
  assign imm_b  = {{19{ir_q[31]}}, ir_q[31], ir_q[7], ir_q[30:25], ir_q[11:8], 1'b0};
  assign imm_u  = {ir_q[31:12], 12'h000};
  assign imm_j  = {{11{ir_q[31]}}, ir_q[31], ir_q[19:12], ir_q[20], ir_q[30:21], 1'b0};

  // Out-of-range indices read as zero; such instructions are flagged illegal anyway.
  assign rs1_val  = (rs1 != 5'd0 && reg_ok(rs1)) ? regs_q[rs1[RegAw-1:0]] : '0;
  assign rs2_val  = (rs2 != 5'd0 && reg_ok(rs2)) ? regs_q[rs2[RegAw-1:0]] : '0;
  assign op_b     = (opcode == OpReg) ? rs2_val : imm_i;
  assign shamt    = op_b[4:0];
  assign mul_res  = rs1_val * rs2_val;
  assign ea       = rs1_val + ((opcode == OpStore) ? imm_s : imm_i);
  assign pc_plus4 = pc_q + 32'd4;

  always_comb begin
    alu_res = '0;
    unique case (funct3)
      3'b000: begin
        if (opcode == OpReg && funct7 == 7'h01) alu_res = mul_res;
        else if (opcode == OpReg && funct7 == 7'h20) alu_res = rs1_val - op_b;
        else alu_res = rs1_val + op_b;
      end
      3'b001: alu_res = rs1_val << shamt;
      3'b010: alu_res = {31'd0, $signed(rs1_val) < $signed(op_b)};
      3'b011: alu_res = {31'd0, rs1_val < op_b};
      3'b100: alu_res = rs1_val ^ op_b;
      3'b101: alu_res = funct7[5] ? 32'($signed(rs1_val) >>> shamt) : rs1_val >> shamt;
      3'b110: alu_res = rs1_val | op_b;
      3'b111: alu_res = rs1_val & op_b;
    endcase
  end

  always_comb begin
    case (funct3)
      3'b000:  br_taken = rs1_val == rs2_val;
      3'b001:  br_taken = rs1_val != rs2_val;
      3'b100:  br_taken = $signed(rs1_val) < $signed(rs2_val);
      3'b101:  br_taken = $signed(rs1_val) >= $signed(rs2_val);
      3'b110:  br_taken = rs1_val < rs2_val;
      3'b111:  br_taken = rs1_val >= rs2_val;
      default: br_taken = 1'b0;
    endcase
  end

  always_comb begin
    illegal = 1'b0;
    use_rd  = 1'b1;
    use_rs1 = 1'b1;
    use_rs2 = 1'b0;
    wb_data = alu_res;
    next_pc = pc_plus4;
    case (opcode)
      OpReg: begin
        use_rs2 = 1'b1;
        if (funct7 == 7'h01) illegal = !ENABLE_M || funct3 != 3'b000;
        else if (funct7 == 7'h20) illegal = funct3 != 3'b000 && funct3 != 3'b101;
        else illegal = funct7 != 7'h00;
      end
      OpImm: begin
        if (funct3 == 3'b001) illegal = funct7 != 7'h00;
        else if (funct3 == 3'b101) illegal = funct7 != 7'h00 && funct7 != 7'h20;
      end
      OpLui: begin
        use_rs1 = 1'b0;
        wb_data = imm_u;
      end
      OpAuipc: begin
        use_rs1 = 1'b0;
        wb_data = pc_q + imm_u;
      end
      OpJal: begin
        use_rs1 = 1'b0;
        wb_data = pc_plus4;
        next_pc = pc_q + imm_j;
      end
      OpJalr: begin
        illegal = funct3 != 3'b000;
        wb_data = pc_plus4;
        next_pc = ea & ~32'd1;
      end
      OpBranch: begin
        use_rd  = 1'b0;
        use_rs2 = 1'b1;
        illegal = funct3 == 3'b010 || funct3 == 3'b011;
        next_pc = br_taken ? pc_q + imm_b : pc_plus4;
      end
      OpLoad:  illegal = funct3 != 3'b010;
      OpStore: begin
        use_rd  = 1'b0;
        use_rs2 = 1'b1;
        illegal = funct3 != 3'b010;
      end
      default: illegal = 1'b1;
    endcase
    if ((use_rd && !reg_ok(rd)) || (use_rs1 && !reg_ok(rs1)) || (use_rs2 && !reg_ok(rs2))) begin
      illegal = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q       <= StFetch;
      pc_q          <= RESET_PC;
      ir_q          <= '0;
      mem_addr_q    <= '0;
      mem_wr_data_q <= '0;
      mem_rd_req_q  <= 1'b0;
      mem_wr_req_q  <= 1'b0;
      out_q         <= '0;
      outen_q       <= 1'b0;
      outflen_q     <= 1'b0;
      halt_q        <= 1'b0;
      issued_q      <= 1'b0;
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else begin
      mem_rd_req_q <= 1'b0;
      mem_wr_req_q <= 1'b0;
      outen_q      <= 1'b0;
      outflen_q    <= 1'b0;
      unique case (state_q)
        StFetch: begin
          if (!mem_busy_i) begin
            mem_addr_q   <= pc_q;
            mem_rd_req_q <= 1'b1;
            state_q      <= StIwait;
          end
        end
        StIwait: begin
          if (mem_ack_i) begin
            ir_q    <= mem_rd_data_i;
            state_q <= StExec;
          end
        end
        StExec: begin
          if (illegal || (opcode == OpStore && ea == HALT_ADDR)) begin
            state_q <= StHalted;
            halt_q  <= 1'b1;
          end else if (opcode == OpLoad ||
                       (opcode == OpStore && ea != OUT_ADDR && ea != OUTF_ADDR)) begin
            // Issue straight from EXEC when the port is free to save a DWAIT cycle.
            state_q  <= StDwait;
            issued_q <= !mem_busy_i;
            if (!mem_busy_i) begin
              mem_addr_q    <= ea;
              mem_wr_data_q <= rs2_val;
              mem_rd_req_q  <= opcode == OpLoad;
              mem_wr_req_q  <= opcode == OpStore;
            end
          end else begin
            state_q <= StFetch;
            pc_q    <= next_pc;
            if (opcode == OpStore) begin
              out_q     <= rs2_val;
              outen_q   <= ea == OUT_ADDR;
              outflen_q <= ea == OUTF_ADDR;
            end
            if (use_rd && rd != 5'd0) regs_q[rd[RegAw-1:0]] <= wb_data;
          end
        end
        StDwait: begin
          if (!issued_q) begin
            if (!mem_busy_i) begin
              issued_q      <= 1'b1;
              mem_addr_q    <= ea;
              mem_wr_data_q <= rs2_val;
              mem_rd_req_q  <= opcode == OpLoad;
              mem_wr_req_q  <= opcode == OpStore;
            end
          end else if (mem_ack_i) begin
            if (opcode == OpLoad && rd != 5'd0) regs_q[rd[RegAw-1:0]] <= mem_rd_data_i;
            issued_q <= 1'b0;
            pc_q     <= pc_plus4;
            state_q  <= StFetch;
          end
        end
        StHalted: halt_q <= 1'b1;
        default:  state_q <= StHalted;
      endcase
    end
  end

  assign mem_addr_o    = mem_addr_q;
  assign mem_wr_data_o = mem_wr_data_q;
  assign mem_wr_req_o  = mem_wr_req_q;
  assign mem_rd_req_o  = mem_rd_req_q;
  assign out_o         = out_q;
  assign outen_o       = outen_q;
  assign outflen_o     = outflen_q;
  assign halt_o        = halt_q;
  assign pc_o          = pc_q;
  assign state_o       = state_q;
  assign x1_o          = regs_q[1];

endmodule
